mdom_scdb_hdr_serializer: RTL
=============================

// Module: mdom_scdb_hdr_serializer
// PURPOSE
//  Parametrised successor to the fixed 113-bit scdb header packer. Packs per-event header fields, with
//  parametrised widths, into one header vector, then streams it out as WORD_W-bit words. Handshake is
//  valid/ready, with an optional XOR check word at the end. One pending slot lets the next header be
//  accepted while the current one streams. Sits between the per-channel trigger/LTC capture and the
//  scdb readout FIFO writer.
// PARAMETERS
//  LTC_W     49  event LTC width
//  ADDR_W    12  waveform buffer address width (start/stop)
//  BSUM_W    19  baseline-sum width
//  CH_IDX_W  5   channel index width
//  WORD_W    16  output word width
//  CHK_EN    1   1: append one XOR check word after data words
//  Derived: HDR_W = LTC_W+2*ADDR_W+BSUM_W+CH_IDX_W+16 (113 at defaults); NWORDS = ceil(HDR_W/WORD_W)
// PORTS
//  clk             in   1         clock; single domain
//  rst_n           in   1         synchronous reset, active low
//  evt_ltc         in   LTC_W     header fields; sampled when in_valid&&in_ready
//  start_addr      in   ADDR_W    "
//  stop_addr       in   ADDR_W    "
//  trig_src        in   2         "
//  cnst_run        in   1         "
//  pre_conf        in   5         "
//  sync_rdy        in   1         "
//  bsum            in   BSUM_W    "
//  bsum_len_sel    in   3         "
//  bsum_valid      in   1         "
//  local_coinc     in   1         "
//  partial_wfm     in   1         "
//  continued_wfm   in   1         "
//  channel_idx     in   CH_IDX_W  "
//  in_valid        in   1         header fields valid
//  in_ready        out  1         pending slot empty
//  out_data        out  WORD_W    serialized header word
//  out_valid       out  1         out_data valid
//  out_ready       in   1         downstream accepts word
//  out_first       out  1         out_data is word 0 of a header
//  out_last        out  1         out_data is final word (check word if CHK_EN)
//  busy            out  1         pending slot or shifter occupied
//  hdr_sent_cnt    out  16        headers fully emitted; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset values: in_ready=1; out_valid, out_first, out_last, busy = 0; out_data=0; hdr_sent_cnt=0.
//  Reset mid-header discards pending and shifter contents. No out_last is emitted.
//  Packing (LSB first): ltc, start, stop, trig_src, cnst_run, pre_conf[4:0], sync_rdy, bsum, bsum_len_sel,
//   bsum_valid, local_coinc, partial_wfm, continued_wfm, channel_idx. Zero-pad to NWORDS*WORD_W.
//  in_ready = !pend_full; registered only, no combinational path from out_ready.
//  Accept at edge k fills pend. If shifter idle, the shifter loads at edge k+1 and out_valid rises after
//   edge k+1 (2-cycle latency).
//  FSM: IDLE -> SEND on load. SEND emits word i = hdr[i*WORD_W +: WORD_W], i = 0..NWORDS-1.
//   On handshake of word NWORDS-1: CHK if CHK_EN; otherwise reload from pend if full (back-to-back), else IDLE.
//   CHK emits XOR of all NWORDS data words (precomputed at load). After its handshake: reload or IDLE.
//  Back-to-back: the last-word handshake and the pend->shifter load happen on the same edge. No bubble.
//  Stall: out_data, out_first and out_last are held stable while out_valid && !out_ready.
//  Word counter width is clog2(NWORDS+1). The counter resets to 0 on every load.
//  hdr_sent_cnt increments on the out_last handshake. Modulo 2^16.
//  A new accept cannot coincide with the pend->shifter move, because pend_full blocks it. pend is freed at the load edge.
//  busy = pend_full || (state != IDLE).
// STRUCTURE
//  Package mdom_scdb_hdr_pkg: field widths/offset localparams, hdr_w() and nwords() functions, FSM state encodings.
//  Sub-module mdom_scdb_hdr_pack (combinational, parametrised): fields -> HDR_W vector. Reused by the readout decoder TB.
//  Top module: pend register, shift/word mux, check-word XOR tree, FSM, counters.
// TESTING
//  1 Defaults, CHK_EN=1, out_ready=1, ltc=49'h1_2345_6789_ABCD, ch=5'd7, other fields 0 -> 9 words.
//    word0=16'hABCD, first on w0, last on w8, w8=XOR(w0..w7). hdr_sent_cnt=1.
//  2 Two headers offered on consecutive cycles, out_ready=1 -> 2nd in_ready low until 1st loads.
//    18 words contiguous, no idle cycle between w8 and next w0.
//  3 out_ready toggled 1010..., random fields -> out_data/first/last stable during stalls.
//    Words match the pack model.
//  4 rst_n low during word 4 -> next cycle out_valid=0, in_ready=1, hdr_sent_cnt=0.
//    Next header starts at word0.
//  5 CHK_EN=0, WORD_W=32 -> NWORDS=4, last on word3, top 15 bits of word3 zero.
//  6 Preload hdr_sent_cnt to 0xFFFF via 65535 headers (or force) -> next header wraps it to 0.

Source files
------------

// File: rtl/mdom_scdb_hdr_pkg.sv
// Shared widths, size helpers and FSM encoding for the scdb header serializer.
// The derived header/word counts are computed from the field widths.
package mdom_scdb_hdr_pkg;

    localparam int LTC_W_DEF    = 49;
    localparam int ADDR_W_DEF   = 12;
    localparam int BSUM_W_DEF   = 19;
    localparam int CH_IDX_W_DEF = 5;
    localparam int WORD_W_DEF   = 16;

    // Fixed-width fields: trig_src, cnst_run, pre_conf, sync_rdy, bsum_len_sel and four flag bits.
    localparam int TRIG_W     = 2;
    localparam int PRE_CONF_W = 5;
    localparam int BSUM_LEN_W = 3;
    localparam int FIXED_W    = TRIG_W + 1 + PRE_CONF_W + 1 + BSUM_LEN_W + 4;

    function automatic int hdr_w(input int ltc_w, input int addr_w,
                                 input int bsum_w, input int ch_idx_w);
        return ltc_w + 2 * addr_w + bsum_w + ch_idx_w + FIXED_W;
    endfunction

    function automatic int nwords(input int hdr_bits, input int word_w);
        return (hdr_bits + word_w - 1) / word_w;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_CHK  = 2'd2
    } state_t;

endpackage

// File: rtl/mdom_scdb_hdr_pack.sv
// Combinational packer: per-event header fields into one header vector, LSB first.
// Kept standalone so the readout decoder can reuse the same field layout.
module mdom_scdb_hdr_pack
    import mdom_scdb_hdr_pkg::*;
#(
    parameter int LTC_W    = LTC_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int BSUM_W   = BSUM_W_DEF,
    parameter int CH_IDX_W = CH_IDX_W_DEF
) (
    input  logic [LTC_W-1:0]      evt_ltc,
    input  logic [ADDR_W-1:0]     start_addr,
    input  logic [ADDR_W-1:0]     stop_addr,
    input  logic [TRIG_W-1:0]     trig_src,
    input  logic                  cnst_run,
    input  logic [PRE_CONF_W-1:0] pre_conf,
    input  logic                  sync_rdy,
    input  logic [BSUM_W-1:0]     bsum,
    input  logic [BSUM_LEN_W-1:0] bsum_len_sel,
    input  logic                  bsum_valid,
    input  logic                  local_coinc,
    input  logic                  partial_wfm,
    input  logic                  continued_wfm,
    input  logic [CH_IDX_W-1:0]   channel_idx,
    output logic [hdr_w(LTC_W, ADDR_W, BSUM_W, CH_IDX_W)-1:0] hdr
);

    // Concatenation lists the last-packed field first, so evt_ltc lands at bit 0.
    assign hdr = {channel_idx, continued_wfm, partial_wfm, local_coinc, bsum_valid,
                  bsum_len_sel, bsum, sync_rdy, pre_conf, cnst_run, trig_src,
                  stop_addr, start_addr, evt_ltc};

endmodule

// File: rtl/mdom_scdb_hdr_serializer.sv
// Header serializer: one pending slot feeding a word shifter that streams the packed
// header as WORD_W-bit words, optionally followed by an XOR check word.
module mdom_scdb_hdr_serializer
    import mdom_scdb_hdr_pkg::*;
#(
    parameter int LTC_W    = LTC_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int BSUM_W   = BSUM_W_DEF,
    parameter int CH_IDX_W = CH_IDX_W_DEF,
    parameter int WORD_W   = WORD_W_DEF,
    parameter bit CHK_EN   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LTC_W-1:0]      evt_ltc,
    input  logic [ADDR_W-1:0]     start_addr,
    input  logic [ADDR_W-1:0]     stop_addr,
    input  logic [1:0]            trig_src,
    input  logic                  cnst_run,
    input  logic [4:0]            pre_conf,
    input  logic                  sync_rdy,
    input  logic [BSUM_W-1:0]     bsum,
    input  logic [2:0]            bsum_len_sel,
    input  logic                  bsum_valid,
    input  logic                  local_coinc,
    input  logic                  partial_wfm,
    input  logic                  continued_wfm,
    input  logic [CH_IDX_W-1:0]   channel_idx,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WORD_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_first,
    output logic                  out_last,
    output logic                  busy,
    output logic [15:0]           hdr_sent_cnt
);

    localparam int HDR_W  = hdr_w(LTC_W, ADDR_W, BSUM_W, CH_IDX_W);
    localparam int NWORDS = nwords(HDR_W, WORD_W);
    localparam int DATA_W = NWORDS * WORD_W;
    localparam int CNT_W  = $clog2(NWORDS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

    logic [HDR_W-1:0]  hdr_vec;
    logic [DATA_W-1:0] pend_data;
    logic [DATA_W-1:0] shift_q;
    logic [WORD_W-1:0] chk_calc;
    logic [WORD_W-1:0] chk_q;
    logic [CNT_W-1:0]  word_cnt;
    logic              pend_full;
    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              load;
    logic              data_hs;
    logic              last_data;

    mdom_scdb_hdr_pack #(
        .LTC_W    (LTC_W),
        .ADDR_W   (ADDR_W),
        .BSUM_W   (BSUM_W),
        .CH_IDX_W (CH_IDX_W)
    ) u_pack (
        .evt_ltc       (evt_ltc),
        .start_addr    (start_addr),
        .stop_addr     (stop_addr),
        .trig_src      (trig_src),
        .cnst_run      (cnst_run),
        .pre_conf      (pre_conf),
        .sync_rdy      (sync_rdy),
        .bsum          (bsum),
        .bsum_len_sel  (bsum_len_sel),
        .bsum_valid    (bsum_valid),
        .local_coinc   (local_coinc),
        .partial_wfm   (partial_wfm),
        .continued_wfm (continued_wfm),
        .channel_idx   (channel_idx),
        .hdr           (hdr_vec)
    );

    // in_ready depends only on the pend flop, never on out_ready.
    assign in_ready  = !pend_full;
    assign accept    = in_valid && !pend_full;
    assign busy      = pend_full || (state != ST_IDLE);
    assign last_data = (state == ST_SEND) && (word_cnt == LAST_IDX);
    assign data_hs   = (state == ST_SEND) && out_ready;

    always_comb begin
        chk_calc = '0;
        for (int i = 0; i < NWORDS; i++) begin
            chk_calc ^= pend_data[i*WORD_W +: WORD_W];
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        load      = 1'b0;
        out_valid = 1'b0;
        out_first = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        case (state)
            ST_IDLE: begin
                if (pend_full) begin
                    load      = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                out_valid = 1'b1;
                out_data  = shift_q[WORD_W-1:0];
                out_first = (word_cnt == '0);
                out_last  = last_data && !CHK_EN;
                if (out_ready && last_data) begin
                    if (CHK_EN) begin
                        state_nxt = ST_CHK;
                    end else if (pend_full) begin
                        load      = 1'b1;
                        state_nxt = ST_SEND;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_CHK: begin
                out_valid = 1'b1;
                out_data  = chk_q;
                out_last  = 1'b1;
                if (out_ready) begin
                    if (pend_full) begin
                        load      = 1'b1;
                        state_nxt = ST_SEND;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            pend_full    <= 1'b0;
            word_cnt     <= '0;
            hdr_sent_cnt <= '0;
        end else begin
            state <= state_nxt;
            // accept needs an empty slot and load needs a full one, so they never coincide.
            if (load) begin
                pend_full <= 1'b0;
            end else if (accept) begin
                pend_full <= 1'b1;
            end
            if (load) begin
                word_cnt <= '0;
            end else if (data_hs) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
            if (out_valid && out_ready && out_last) begin
                hdr_sent_cnt <= hdr_sent_cnt + 16'd1;
            end
        end
    end

    // NOTE: datapath registers carry no reset; every use is qualified by pend_full or state.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_data <= DATA_W'(hdr_vec);
        end
        if (load) begin
            shift_q <= pend_data;
            chk_q   <= chk_calc;
        end else if (data_hs) begin
            shift_q <= shift_q >> WORD_W;
        end
    end

endmodule
